bcd_xs3_word_conv: RTL and testbench

Sequential, parametrised BCD/Excess-3 code converter for packed multi-digit words. It converts one 4-bit digit per clock, in either direction, with a per-digit invalid-code report. It sits between a valid/ready producer and consumer in the code-converter datapath and supersedes single-digit combinational conversion wherever whole decimal words move through the design.

---
 rtl/bcd_xs3_word_conv.sv | 138 +++++++++++++
 tb/tb_bcd_xs3_word_conv.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_xs3_word_conv.sv
// Multi-digit BCD <-> Excess-3 word converter, one digit per clock, with per-digit invalid-code mask.
// Latency: result DIGITS edges after acceptance; in_ready low from acceptance until out_ready is seen in DONE.
module bcd_xs3_word_conv #(
   parameter int DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [4*DIGITS-1:0]   in_data,
   input  logic                  in_mode,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [4*DIGITS-1:0]   out_data,
   output logic [DIGITS-1:0]     out_err_mask,
   output logic                  out_err
);

   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [4*DIGITS-1:0]   word_q, word_d;
   logic                  mode_q, mode_d;
   logic [4*DIGITS-1:0]   res_q, res_d;
   logic [DIGITS-1:0]     mask_q, mask_d;
   logic                  err_q, err_d;

   logic [3:0]            cur_digit;
   logic [3:0]            cur_res;
   logic                  cur_bad;

   always_comb begin
      cur_digit = 4'h0;
      for (int i = 0; i < DIGITS; i++) begin
         if (idx_q == IDX_W'(i)) begin
            cur_digit = word_q[4*i +: 4];
         end
      end
   end

   // Invalid codes map to 4'hF so a bad digit is obvious in the packed result.
   always_comb begin
      cur_bad = 1'b1;
      cur_res = 4'hF;
      if (!mode_q) begin
         if (cur_digit <= 4'd9) begin
            cur_bad = 1'b0;
            cur_res = cur_digit + 4'd3;
         end
      end else begin
         if ((cur_digit >= 4'd3) && (cur_digit <= 4'd12)) begin
            cur_bad = 1'b0;
            cur_res = cur_digit - 4'd3;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      word_d    = word_q;
      mode_d    = mode_q;
      res_d     = res_q;
      mask_d    = mask_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;

      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               word_d  = in_data;
               mode_d  = in_mode;
               res_d   = '0;
               mask_d  = '0;
               idx_d   = '0;
               state_d = CONV;
            end
         end
         CONV: begin
            for (int i = 0; i < DIGITS; i++) begin
               if (idx_q == IDX_W'(i)) begin
                  res_d[4*i +: 4] = cur_res;
                  mask_d[i]       = cur_bad;
               end
            end
            if (idx_q == IDX_W'(DIGITS-1)) begin
               state_d = DONE;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      err_d = |mask_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         word_q  <= '0;
         mode_q  <= 1'b0;
         res_q   <= '0;
         mask_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         word_q  <= word_d;
         mode_q  <= mode_d;
         res_q   <= res_d;
         mask_q  <= mask_d;
         err_q   <= err_d;
      end
   end

   assign out_data     = res_q;
   assign out_err_mask = mask_q;
   assign out_err      = err_q;

endmodule

// File: tb/tb_bcd_xs3_word_conv.sv
// Scoreboard bench for bcd_xs3_word_conv: a 4-digit instance plus a 1-digit instance.
module tb_bcd_xs3_word_conv;

   localparam int D = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic            in_valid, in_ready, in_mode;
   logic            out_valid, out_ready, out_err;
   logic [4*D-1:0]  in_data, out_data;
   logic [D-1:0]    out_err_mask;

   logic            s_in_valid, s_in_ready, s_in_mode;
   logic            s_out_valid, s_out_ready, s_out_err;
   logic [3:0]      s_in_data, s_out_data;
   logic [0:0]      s_out_err_mask;

   always #5 clk = ~clk;

   bcd_xs3_word_conv #(.DIGITS(D)) u_dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .in_mode      (in_mode),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .out_err_mask (out_err_mask),
      .out_err      (out_err)
   );

   bcd_xs3_word_conv #(.DIGITS(1)) u_dut1 (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (s_in_valid),
      .in_ready     (s_in_ready),
      .in_data      (s_in_data),
      .in_mode      (s_in_mode),
      .out_valid    (s_out_valid),
      .out_ready    (s_out_ready),
      .out_data     (s_out_data),
      .out_err_mask (s_out_err_mask),
      .out_err      (s_out_err)
   );

   typedef struct packed {
      logic [4*D-1:0] dat;
      logic [D-1:0]   msk;
   } exp_t;

   typedef struct {
      logic [15:0] w;
      logic        m;
      logic [15:0] d;
      logic [3:0]  k;
   } vec_t;

   typedef struct {
      logic [3:0] w;
      logic       m;
      logic [3:0] d;
      logic       k;
   } vec1_t;

   exp_t sb_q[$];
   int   n_chk  = 0;
   int   n_pass = 0;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      n_chk++;
      if (obs === exp_v) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp_v);
   endtask

   function automatic exp_t model(input logic [4*D-1:0] w, input logic m);
      exp_t       r;
      logic [3:0] dg;
      logic       ok;
      r = '0;
      for (int i = 0; i < D; i++) begin
         dg = w[4*i +: 4];
         ok = m ? (dg >= 4'd3 && dg <= 4'd12) : (dg <= 4'd9);
         if (!ok) begin
            r.dat[4*i +: 4] = 4'hF;
            r.msk[i]        = 1'b1;
         end else begin
            r.dat[4*i +: 4] = m ? dg - 4'd3 : dg + 4'd3;
         end
      end
      return r;
   endfunction

   // Called at a negedge; returns 1ns after the acceptance edge with inputs scrambled.
   task automatic send(input logic [15:0] w, input logic m, input logic [15:0] ed, input logic [3:0] em);
      exp_t e;
      int   n = 0;
      while (!in_ready && n < 64) begin
         @(negedge clk);
         n++;
      end
      check_val("send_in_ready", in_ready, 1);
      in_valid = 1'b1;
      in_data  = w;
      in_mode  = m;
      e.dat    = ed;
      e.msk    = em;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_mode  = ~m;
      in_data  = ~w;
   endtask

   task automatic wait_out(input string tag, output exp_t e);
      int lat = 0;
      do begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end while (!out_valid && lat < 64);
      check_val({tag, "_lat"}, lat, D);
      if (sb_q.size() == 0) begin
         check_val({tag, "_sb_empty"}, sb_q.size(), 1);
         e = '0;
      end else begin
         e = sb_q.pop_front();
      end
      check_val({tag, "_valid"}, out_valid, 1);
      check_val({tag, "_data"}, out_data, e.dat);
      check_val({tag, "_mask"}, out_err_mask, e.msk);
      check_val({tag, "_err"}, out_err, |e.msk);
      check_val({tag, "_in_ready_lo"}, in_ready, 0);
   endtask

   task automatic release_out(input string tag, input exp_t e);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      @(negedge clk);
      check_val({tag, "_in_ready_hi"}, in_ready, 1);
      check_val({tag, "_valid_lo"}, out_valid, 0);
      check_val({tag, "_data_hold"}, out_data, e.dat);
      check_val({tag, "_mask_hold"}, out_err_mask, e.msk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, n_chk=%0d", n_chk);
      $fatal(1);
   end

   initial begin
      vec_t  vecs[5];
      vec1_t v1[3];
      exp_t  e, mdl;
      logic [15:0] w;
      logic        m;

      vecs[0] = '{16'h1234, 1'b0, 16'h4567, 4'b0000};
      vecs[1] = '{16'h4567, 1'b1, 16'h1234, 4'b0000};
      vecs[2] = '{16'h3C3C, 1'b1, 16'h0909, 4'b0000};
      vecs[3] = '{16'h9A05, 1'b0, 16'hCF38, 4'b0100};
      vecs[4] = '{16'h0012, 1'b1, 16'hFFFF, 4'b1111};
      v1[0]   = '{4'h7, 1'b0, 4'hA, 1'b0};
      v1[1]   = '{4'hB, 1'b1, 4'h8, 1'b0};
      v1[2]   = '{4'hB, 1'b0, 4'hF, 1'b1};

      rst = 1'b1;
      in_valid = 1'b0; in_data = '0; in_mode = 1'b0; out_ready = 1'b0;
      s_in_valid = 1'b0; s_in_data = '0; s_in_mode = 1'b0; s_out_ready = 1'b0;
      #12;
      check_val("rst_in_ready", in_ready, 1);
      check_val("rst_valid", out_valid, 0);
      check_val("rst_data", out_data, 0);
      check_val("rst_mask", out_err_mask, 0);
      check_val("rst_err", out_err, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      foreach (vecs[i]) begin
         send(vecs[i].w, vecs[i].m, vecs[i].d, vecs[i].k);
         wait_out($sformatf("vec%0d", i), e);
         release_out($sformatf("vec%0d", i), e);
      end

      for (int i = 0; i < 6; i++) begin
         w   = 16'($urandom);
         m   = 1'($urandom_range(0, 1));
         mdl = model(w, m);
         send(w, m, mdl.dat, mdl.msk);
         wait_out($sformatf("rnd%0d", i), e);
         release_out($sformatf("rnd%0d", i), e);
      end

      // Backpressure: a new word waits while DONE is stalled.
      send(16'h2580, 1'b0, 16'h58B3, 4'b0000);
      wait_out("bp", e);
      in_valid = 1'b1;
      in_data  = 16'h0719;
      in_mode  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         @(negedge clk);
         check_val($sformatf("bp_hold_valid%0d", i), out_valid, 1);
         check_val($sformatf("bp_hold_data%0d", i), out_data, 16'h58B3);
         check_val($sformatf("bp_in_ready%0d", i), in_ready, 0);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      @(negedge clk);
      check_val("bp_in_ready_after", in_ready, 1);
      check_val("bp_valid_after", out_valid, 0);
      e.dat = 16'hF4F6;
      e.msk = 4'b1010;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_mode  = 1'b0;
      wait_out("bp_new", e);
      release_out("bp_new", e);

      // Reset two digits into a conversion.
      send(16'h1234, 1'b0, 16'h4567, 4'b0000);
      @(posedge clk);
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check_val("mid_rst_valid", out_valid, 0);
      check_val("mid_rst_data", out_data, 0);
      check_val("mid_rst_mask", out_err_mask, 0);
      check_val("mid_rst_err", out_err, 0);
      check_val("mid_rst_in_ready", in_ready, 1);
      sb_q.delete();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_val("post_rst_in_ready", in_ready, 1);
      check_val("post_rst_valid", out_valid, 0);
      send(16'h0099, 1'b0, 16'h33CC, 4'b0000);
      wait_out("post_rst", e);
      release_out("post_rst", e);
      check_val("sb_drained", sb_q.size(), 0);

      // Single-digit instance: result one edge after acceptance.
      foreach (v1[i]) begin
         @(negedge clk);
         check_val($sformatf("d1_%0d_in_ready", i), s_in_ready, 1);
         s_in_valid = 1'b1;
         s_in_data  = v1[i].w;
         s_in_mode  = v1[i].m;
         @(posedge clk);
         #1;
         s_in_valid = 1'b0;
         s_in_mode  = ~v1[i].m;
         @(negedge clk);
         check_val($sformatf("d1_%0d_conv_valid", i), s_out_valid, 0);
         @(posedge clk);
         @(negedge clk);
         check_val($sformatf("d1_%0d_valid", i), s_out_valid, 1);
         check_val($sformatf("d1_%0d_data", i), s_out_data, v1[i].d);
         check_val($sformatf("d1_%0d_mask", i), s_out_err_mask, v1[i].k);
         check_val($sformatf("d1_%0d_err", i), s_out_err, v1[i].k);
         check_val($sformatf("d1_%0d_in_ready_lo", i), s_in_ready, 0);
         s_out_ready = 1'b1;
         @(posedge clk);
         #1;
         s_out_ready = 1'b0;
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
